// File: rtl/rc_pipelined.sv
`default_nettype none
//============================================================================
// Module      : rc_pipelined
// Description : Registered XY / west-first routing computation for one input
//               VC of a 2D-mesh router. It holds the route until tailRelease.
//               Optional escape-VC reservation: define RC_ESCAPE_VC_EN.
//               The tail-release port is named tailRelease because "release"
//               is a reserved word.
// Revision    : 1.0 - initial release
//============================================================================
`ifndef N
`define N 5
`endif
`ifndef V
`define V 4
`endif

module rc_pipelined #(
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0,
  parameter int COORD_W = 4,
  parameter int ALGO    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 headValid,
  output logic                 headReady,
  input  logic [2*COORD_W-1:0] dst,
  input  logic [`N-1:0]        portBusy,
  input  logic                 tailRelease,
  output logic                 routeValid,
  output logic [`N-1:0]        candidateOutPort,
  output logic [`V-1:0]        candidateOutVC,
  output logic [`N-1:0]        escapeOutPort
);

  localparam logic [`N-1:0] C_PORT_ONE  = {{(`N-1){1'b0}}, 1'b1};
  localparam logic [`N-1:0] C_LOCAL     = C_PORT_ONE;
  localparam logic [`N-1:0] C_EAST      = C_PORT_ONE << 1;
  localparam logic [`N-1:0] C_WEST      = C_PORT_ONE << 2;
  localparam logic [`N-1:0] C_NORTH     = C_PORT_ONE << 3;
  localparam logic [`N-1:0] C_SOUTH     = C_PORT_ONE << 4;
  localparam logic [`V-1:0] C_VC_ALL    = {`V{1'b1}};
  localparam logic [`V-1:0] C_VC_ESCAPE = {{(`V-1){1'b0}}, 1'b1};
  localparam logic [COORD_W:0] C_CUR_X  = {1'b0, CUR_X[COORD_W-1:0]};
  localparam logic [COORD_W:0] C_CUR_Y  = {1'b0, CUR_Y[COORD_W-1:0]};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*COORD_W-1:0] r_dst;

  logic [COORD_W:0] w_dx, w_dy;
  logic             w_dx_neg, w_dx_pos, w_dy_neg, w_dy_pos;
  logic [`N-1:0]    w_xy_port, w_wf_set, w_wf_free, w_wf_port, w_final_port;
  logic             w_wf_multi, w_final_multi;
  logic [`V-1:0]    w_vc;
  logic [`N-1:0]    w_esc;

  // Offsets are two's complement (COORD_W+1) bits; the MSB is the sign.
  assign w_dx     = {1'b0, r_dst[2*COORD_W-1:COORD_W]} - C_CUR_X;
  assign w_dy     = {1'b0, r_dst[COORD_W-1:0]} - C_CUR_Y;
  assign w_dx_neg = w_dx[COORD_W];
  assign w_dy_neg = w_dy[COORD_W];
  assign w_dx_pos = !w_dx_neg && (w_dx != '0);
  assign w_dy_pos = !w_dy_neg && (w_dy != '0);

  assign headReady = (r_state == IDLE);

  always_comb begin
    w_xy_port = C_LOCAL;
    if (w_dx_pos)      w_xy_port = C_EAST;
    else if (w_dx_neg) w_xy_port = C_WEST;
    else if (w_dy_pos) w_xy_port = C_NORTH;
    else if (w_dy_neg) w_xy_port = C_SOUTH;

    w_wf_set = '0;
    if (w_dx_neg) begin
      w_wf_set = C_WEST;
    end else begin
      if (w_dx_pos) w_wf_set = w_wf_set | C_EAST;
      if (w_dy_pos) w_wf_set = w_wf_set | C_NORTH;
      if (w_dy_neg) w_wf_set = w_wf_set | C_SOUTH;
      if (w_wf_set == '0) w_wf_set = C_LOCAL;
    end

    // Prune busy candidates only when a free alternative remains.
    w_wf_free  = w_wf_set & ~portBusy;
    w_wf_multi = |(w_wf_set & (w_wf_set - C_PORT_ONE));
    w_wf_port  = (w_wf_multi && (w_wf_free != '0)) ? w_wf_free : w_wf_set;

    w_final_port  = (ALGO == 1) ? w_wf_port : w_xy_port;
    w_final_multi = |(w_final_port & (w_final_port - C_PORT_ONE));

`ifdef RC_ESCAPE_VC_EN
    // Adaptive choices leave VC0 free for the deadlock-free XY escape path.
    if ((ALGO == 1) && w_final_multi) begin
      w_vc  = C_VC_ALL & ~C_VC_ESCAPE;
      w_esc = w_xy_port;
    end else begin
      w_vc  = C_VC_ALL;
      w_esc = w_final_port;
    end
`else
    w_vc  = C_VC_ALL;
    w_esc = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_dst            <= '0;
      routeValid       <= 1'b0;
      candidateOutPort <= '0;
      candidateOutVC   <= '0;
      escapeOutPort    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (headValid) begin
            r_dst   <= dst;
            r_state <= CALC;
          end
        end
        CALC: begin
          routeValid       <= 1'b1;
          candidateOutPort <= w_final_port;
          candidateOutVC   <= w_vc;
          escapeOutPort    <= w_esc;
          r_state          <= HOLD;
        end
        HOLD: begin
          if (tailRelease) begin
            routeValid       <= 1'b0;
            candidateOutPort <= '0;
            candidateOutVC   <= '0;
            escapeOutPort    <= '0;
            r_state          <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc_pipelined.sv
`default_nettype none
//============================================================================
// Module      : tb_rc_pipelined
// Description : Table-driven bench running XY and west-first instances in
//               lockstep, plus hold/release and reset sequences.
// Revision    : 1.0 - initial release
//============================================================================
`ifndef N
`define N 5
`endif
`ifndef V
`define V 4
`endif

module tb_rc_pipelined;

  logic       clk = 1'b0;
  logic       rst;
  logic       headValid;
  logic [7:0] dst;
  logic [4:0] portBusy;
  logic       tailRelease;

  logic       hr0, rv0, hr1, rv1;
  logic [4:0] cp0, ep0, cp1, ep1;
  logic [3:0] cv0, cv1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rc_pipelined #(.CUR_X(1), .CUR_Y(1), .COORD_W(4), .ALGO(0)) u_xy (
    .clk(clk), .rst(rst), .headValid(headValid), .headReady(hr0), .dst(dst),
    .portBusy(portBusy), .tailRelease(tailRelease), .routeValid(rv0),
    .candidateOutPort(cp0), .candidateOutVC(cv0), .escapeOutPort(ep0)
  );

  rc_pipelined #(.CUR_X(1), .CUR_Y(1), .COORD_W(4), .ALGO(1)) u_wf (
    .clk(clk), .rst(rst), .headValid(headValid), .headReady(hr1), .dst(dst),
    .portBusy(portBusy), .tailRelease(tailRelease), .routeValid(rv1),
    .candidateOutPort(cp1), .candidateOutVC(cv1), .escapeOutPort(ep1)
  );

  typedef struct {
    logic [7:0] dst;
    logic [4:0] busy;
    logic [4:0] exp_xy;
    logic [4:0] exp_wf;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_vc(input int algo, input logic [4:0] p);
`ifdef RC_ESCAPE_VC_EN
    return (algo == 1 && $countones(p) > 1) ? 4'b1110 : 4'b1111;
`else
    return 4'b1111;
`endif
  endfunction

  function automatic logic [4:0] exp_esc(input int algo, input logic [4:0] pxy, input logic [4:0] pwf);
`ifdef RC_ESCAPE_VC_EN
    if (algo == 0) return pxy;
    return ($countones(pwf) > 1) ? pxy : pwf;
`else
    return 5'b0;
`endif
  endfunction

  task automatic check_route(input string tag, input logic [4:0] pxy, input logic [4:0] pwf);
    check({tag, "_rv0"}, rv0, 1);
    check({tag, "_port0"}, cp0, pxy);
    check({tag, "_vc0"}, cv0, exp_vc(0, pxy));
    check({tag, "_esc0"}, ep0, exp_esc(0, pxy, pwf));
    check({tag, "_rdy0"}, hr0, 0);
    check({tag, "_rv1"}, rv1, 1);
    check({tag, "_port1"}, cp1, pwf);
    check({tag, "_vc1"}, cv1, exp_vc(1, pwf));
    check({tag, "_esc1"}, ep1, exp_esc(1, pxy, pwf));
    check({tag, "_rdy1"}, hr1, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy0"}, hr0, 1);
    check({tag, "_rv0"}, rv0, 0);
    check({tag, "_outs0"}, {cp0, cv0, ep0}, 0);
    check({tag, "_rdy1"}, hr1, 1);
    check({tag, "_rv1"}, rv1, 0);
    check({tag, "_outs1"}, {cp1, cv1, ep1}, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] d, input logic [4:0] b);
    headValid = 1'b1;
    dst       = d;
    portBusy  = b;
    step();
    headValid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, "_pre_rdy0"}, hr0, 1);
    check({tag, "_pre_rdy1"}, hr1, 1);
    accept(v.dst, v.busy);
    check({tag, "_calc_rdy0"}, hr0, 0);
    check({tag, "_calc_rv0"}, rv0, 0);
    check({tag, "_calc_rv1"}, rv1, 0);
    step();
    check_route(tag, v.exp_xy, v.exp_wf);
    tailRelease = 1'b1;
    step();
    tailRelease = 1'b0;
    check_idle({tag, "_rel"});
  endtask

  initial begin
    //        dst     busy      xy        west-first
    vecs[0]  = '{8'h31, 5'b00000, 5'b00010, 5'b00010};
    vecs[1]  = '{8'h11, 5'b00000, 5'b00001, 5'b00001};
    vecs[2]  = '{8'h11, 5'b11111, 5'b00001, 5'b00001};
    vecs[3]  = '{8'h10, 5'b00000, 5'b10000, 5'b10000};
    vecs[4]  = '{8'h32, 5'b00000, 5'b00010, 5'b01010};
    vecs[5]  = '{8'h32, 5'b00010, 5'b00010, 5'b01000};
    vecs[6]  = '{8'h32, 5'b01010, 5'b00010, 5'b01010};
    vecs[7]  = '{8'h02, 5'b00000, 5'b00100, 5'b00100};
    vecs[8]  = '{8'h02, 5'b00100, 5'b00100, 5'b00100};
    vecs[9]  = '{8'h30, 5'b10000, 5'b00010, 5'b00010};
    vecs[10] = '{8'h12, 5'b01000, 5'b01000, 5'b01000};
    vecs[11] = '{8'hF0, 5'b00000, 5'b00010, 5'b10010};
    vecs[12] = '{8'h1F, 5'b00000, 5'b01000, 5'b01000};
    vecs[13] = '{8'h00, 5'b00000, 5'b00100, 5'b00100};
    vecs[14] = '{8'h23, 5'b01000, 5'b00010, 5'b00010};
    vecs[15] = '{8'h21, 5'b00010, 5'b00010, 5'b00010};

    rst = 1'b1; headValid = 1'b0; dst = '0; portBusy = '0; tailRelease = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle("reset");

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Hold: outputs frozen while inputs wiggle; head in release cycle ignored.
    accept(8'h32, 5'b00000);
    step();
    for (int c = 0; c < 10; c++) begin
      dst       = 8'($urandom);
      portBusy  = 5'($urandom);
      headValid = 1'($urandom_range(0, 1));
      step();
      check_route($sformatf("hold%0d", c), 5'b00010, 5'b01010);
    end
    headValid   = 1'b1;
    dst         = 8'h02;
    tailRelease = 1'b1;
    step();
    tailRelease = 1'b0;
    headValid   = 1'b0;
    check_idle("hold_rel");
    step();
    check_idle("hold_noacc");

    // Release during CALC is ignored; the route still lands in HOLD.
    accept(8'h30, 5'b00000);
    tailRelease = 1'b1;
    step();
    check_route("calc_rel", 5'b00010, 5'b10010);
    step();
    tailRelease = 1'b0;
    check_idle("calc_rel_free");

    // Reset in CALC.
    accept(8'h31, 5'b00000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_calc");
    step();
    check_idle("rst_calc_stay");

    // Reset in HOLD.
    accept(8'h32, 5'b00010);
    step();
    check_route("pre_rst_hold", 5'b00010, 5'b01000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_hold");

    // Release pulses in IDLE have no effect.
    tailRelease = 1'b1;
    step();
    step();
    tailRelease = 1'b0;
    check_idle("idle_rel");
    run_vec(vecs[4], 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
